// File: rtl/relogio_set_ctrl_if.sv
// Signal bundle between the time-setting sequencer, the board buttons/1 Hz divider and the counter chain.
// master = sequencer side, slave = board/chain side.
interface relogio_set_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_h1;
    logic [3:0] cur_h0;
    logic [3:0] cur_m1;
    logic [3:0] cur_m0;
    logic       run_en;
    logic       load;
    logic [3:0] ld_h1;
    logic [3:0] ld_h0;
    logic [3:0] ld_m1;
    logic [3:0] ld_m0;
    logic [1:0] mode;
    logic       blank_h;
    logic       blank_m;

    // load is a single-cycle strobe; the chain samples ld_* only while load=1.
    modport master (
        input  tick_1hz, btn_mode, btn_inc, cur_h1, cur_h0, cur_m1, cur_m0,
        output run_en, load, ld_h1, ld_h0, ld_m1, ld_m0, mode, blank_h, blank_m
    );

    modport slave (
        output tick_1hz, btn_mode, btn_inc, cur_h1, cur_h0, cur_m1, cur_m0,
        input  run_en, load, ld_h1, ld_h0, ld_m1, ld_m0, mode, blank_h, blank_m
    );
endinterface

// File: rtl/relogio_set_ctrl.sv
// HH:MM time-setting sequencer: debounced MODE/INC buttons, SET_H/SET_M editing, one-cycle commit load.
// Optional blinking of the edited digits is built when RELOGIO_SET_BLINK_EN is defined.
module relogio_set_ctrl #(
    parameter int DEB_CYCLES = 500_000,
    parameter int TIMEOUT_S  = 10
) (
    input  logic               Clk,
    input  logic               Clear,
    relogio_set_ctrl_if.master bus
);
    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam int TW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SET_H  = 2'b01,
        ST_SET_M  = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_sync1, r_sync2, r_stable, r_press;
    logic [DW-1:0]  r_deb_cnt [2];
    logic [TW-1:0]  r_tcnt, w_tcnt_nxt;
    logic [3:0]     r_h1, r_h0, r_m1, r_m0;
    logic [3:0]     w_h1_nxt, w_h0_nxt, w_m1_nxt, w_m0_nxt;
    logic [1:0]     w_btn_raw;
    logic           w_press_mode, w_press_inc, w_h_ok, w_m_ok, w_timeout;

    assign w_btn_raw    = {bus.btn_inc, bus.btn_mode};
    assign w_press_mode = r_press[0];
    assign w_press_inc  = r_press[1];

    // Synchronizer plus debounce: a new level is accepted after DEB_CYCLES samples that all differ from the old one.
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_press  <= '0;
            for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        r_stable[i]  <= r_sync2[i];
                        r_press[i]   <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_h_ok = ((bus.cur_h1 < 4'd2) && (bus.cur_h0 <= 4'd9)) ||
                    ((bus.cur_h1 == 4'd2) && (bus.cur_h0 <= 4'd3));
    assign w_m_ok = (bus.cur_m1 <= 4'd5) && (bus.cur_m0 <= 4'd9);
    assign w_timeout = (TIMEOUT_S != 0) && bus.tick_1hz && (int'(r_tcnt) == TIMEOUT_S - 1);

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_h1_nxt    = r_h1;
        w_h0_nxt    = r_h0;
        w_m1_nxt    = r_m1;
        w_m0_nxt    = r_m0;
        case (r_state)
            ST_RUN: begin
                w_tcnt_nxt = '0;
                if (w_press_mode) begin
                    w_state_nxt = ST_SET_H;
                    w_h1_nxt    = w_h_ok ? bus.cur_h1 : 4'd0;
                    w_h0_nxt    = w_h_ok ? bus.cur_h0 : 4'd0;
                    w_m1_nxt    = w_m_ok ? bus.cur_m1 : 4'd0;
                    w_m0_nxt    = w_m_ok ? bus.cur_m0 : 4'd0;
                end
            end
            ST_SET_H, ST_SET_M: begin
                if (w_press_mode) begin
                    w_state_nxt = (r_state == ST_SET_H) ? ST_SET_M : ST_COMMIT;
                    w_tcnt_nxt  = '0;
                end else if (w_press_inc) begin
                    w_tcnt_nxt = '0;
                    if (r_state == ST_SET_H) begin
                        if (r_h1 == 4'd2 && r_h0 == 4'd3) begin
                            w_h1_nxt = 4'd0;
                            w_h0_nxt = 4'd0;
                        end else if (r_h0 == 4'd9) begin
                            w_h1_nxt = r_h1 + 4'd1;
                            w_h0_nxt = 4'd0;
                        end else begin
                            w_h0_nxt = r_h0 + 4'd1;
                        end
                    end else begin
                        // Minute wrap never carries into the hours.
                        if (r_m0 == 4'd9) begin
                            w_m0_nxt = 4'd0;
                            w_m1_nxt = (r_m1 == 4'd5) ? 4'd0 : r_m1 + 4'd1;
                        end else begin
                            w_m0_nxt = r_m0 + 4'd1;
                        end
                    end
                end else if (bus.tick_1hz) begin
                    if (w_timeout) begin
                        w_state_nxt = ST_RUN;
                        w_tcnt_nxt  = '0;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_RUN;
                w_tcnt_nxt  = '0;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_tcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_state <= ST_RUN;
            r_tcnt  <= '0;
            r_h1    <= '0;
            r_h0    <= '0;
            r_m1    <= '0;
            r_m0    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_h1    <= w_h1_nxt;
            r_h0    <= w_h0_nxt;
            r_m1    <= w_m1_nxt;
            r_m0    <= w_m0_nxt;
        end
    end

    assign bus.run_en = (r_state == ST_RUN);
    assign bus.load   = (r_state == ST_COMMIT);
    assign bus.mode   = r_state;
    assign bus.ld_h1  = r_h1;
    assign bus.ld_h0  = r_h0;
    assign bus.ld_m1  = r_m1;
    assign bus.ld_m0  = r_m0;

`ifdef RELOGIO_SET_BLINK_EN
    logic r_blank_h, r_blank_m;

    // Each blink phase restarts at 0 whenever its SET state is entered.
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_blank_h <= 1'b0;
            r_blank_m <= 1'b0;
        end else begin
            r_blank_h <= (r_state == ST_SET_H && w_state_nxt == ST_SET_H) ? (r_blank_h ^ bus.tick_1hz) : 1'b0;
            r_blank_m <= (r_state == ST_SET_M && w_state_nxt == ST_SET_M) ? (r_blank_m ^ bus.tick_1hz) : 1'b0;
        end
    end

    assign bus.blank_h = r_blank_h;
    assign bus.blank_m = r_blank_m;
`else
    assign bus.blank_h = 1'b0;
    assign bus.blank_m = 1'b0;
`endif
endmodule

// File: tb/tb_relogio_set_ctrl.sv
// Bench for relogio_set_ctrl: behavioural time-setting model checked every cycle plus directed literal checks.
module tb_relogio_set_ctrl;
    localparam int DEB = 4;
    localparam int TMO = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    relogio_set_ctrl_if bus();

    relogio_set_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_S(TMO)) dut (
        .Clk   (clk),
        .Clear (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Times are plain integers; a button press is "last DEB synchronized samples all opposite the accepted level".
    int m_st, m_h, m_m, m_t;
    bit m_bh, m_bm;
    bit acc [2];
    bit prs [2];
    bit hist [2][DEB+2];

    function automatic int cap_h();
        int v;
        v = int'(bus.cur_h1) * 10 + int'(bus.cur_h0);
        return (bus.cur_h0 <= 9 && bus.cur_h1 <= 9 && v <= 23) ? v : 0;
    endfunction

    function automatic int cap_m();
        int v;
        v = int'(bus.cur_m1) * 10 + int'(bus.cur_m0);
        return (bus.cur_m0 <= 9 && bus.cur_m1 <= 9 && v <= 59) ? v : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_h = 0; m_m = 0; m_t = 0; m_bh = 0; m_bm = 0;
            for (int b = 0; b < 2; b++) begin
                acc[b] = 0;
                prs[b] = 0;
                for (int j = 0; j < DEB + 2; j++) hist[b][j] = 0;
            end
        end else begin
            int  nst;
            bit  pm, pi, tk, all_opp;
            pm = prs[0]; pi = prs[1]; tk = bus.tick_1hz;
            nst = m_st;
            case (m_st)
                0: if (pm) begin nst = 1; m_h = cap_h(); m_m = cap_m(); m_t = 0; end
                1, 2: begin
                    if (pm) begin
                        nst = m_st + 1; m_t = 0;
                    end else if (pi) begin
                        if (m_st == 1) m_h = (m_h + 1) % 24;
                        else           m_m = (m_m + 1) % 60;
                        m_t = 0;
                    end else if (tk) begin
                        m_t++;
                        if (m_t == TMO) begin nst = 0; m_t = 0; end
                    end
                end
                default: nst = 0;
            endcase
            m_bh = (m_st == 1 && nst == 1) ? (m_bh ^ tk) : 1'b0;
            m_bm = (m_st == 2 && nst == 2) ? (m_bm ^ tk) : 1'b0;
            m_st = nst;
            for (int b = 0; b < 2; b++) begin
                for (int j = DEB + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
                hist[b][0] = (b == 0) ? bus.btn_mode : bus.btn_inc;
                all_opp = 1;
                for (int j = 2; j < DEB + 2; j++) if (hist[b][j] == acc[b]) all_opp = 0;
                if (all_opp) begin acc[b] = ~acc[b]; prs[b] = acc[b]; end
                else prs[b] = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            int eh, em;
            eh = m_st; em = 0;
            check("mode", {30'd0, bus.mode}, m_st);
            check("run_en", {31'd0, bus.run_en}, (m_st == 0) ? 1 : 0);
            check("load", {31'd0, bus.load}, (m_st == 3) ? 1 : 0);
            check("ld_hhmm", {16'd0, bus.ld_h1, bus.ld_h0, bus.ld_m1, bus.ld_m0},
                  ((m_h / 10) << 12) | ((m_h % 10) << 8) | ((m_m / 10) << 4) | (m_m % 10));
`ifdef RELOGIO_SET_BLINK_EN
            eh = m_bh; em = m_bm;
`else
            eh = 0; em = 0;
`endif
            check("blank", {30'd0, bus.blank_h, bus.blank_m}, (eh << 1) | em);
        end
    end

    // ---------------- load monitor ----------------
    int          load_cnt = 0;
    logic [15:0] last_ld  = '0;
    logic        prev_load = 1'b0;
    logic        run_after = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_load) run_after = bus.run_en;
            if (bus.load) begin
                load_cnt++;
                last_ld = {bus.ld_h1, bus.ld_h0, bus.ld_m1, bus.ld_m0};
            end
            prev_load = bus.load;
        end else begin
            prev_load = 1'b0;
        end
    end

    // ---------------- drivers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        @(negedge clk);
        if (b == 0) bus.btn_mode = 1'b1; else bus.btn_inc = 1'b1;
        cyc(DEB + 6);
        if (b == 0) bus.btn_mode = 1'b0; else bus.btn_inc = 1'b0;
        cyc(DEB + 6);
    endtask

    task automatic tick();
        @(negedge clk) bus.tick_1hz = 1'b1;
        @(negedge clk) bus.tick_1hz = 1'b0;
        cyc(2);
    endtask

    task automatic set_cur(input logic [3:0] h1, h0, m1, m0);
        bus.cur_h1 = h1; bus.cur_h0 = h0; bus.cur_m1 = m1; bus.cur_m0 = m0;
    endtask

    initial begin
        int lc;
        int hold_m, hold_i;
        bus.tick_1hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        set_cur(4'd0, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;

        // Reset state after idle
        cyc(100);
        check("rst_mode", {30'd0, bus.mode}, 0);
        check("rst_run_en", {31'd0, bus.run_en}, 1);
        check("rst_load", {31'd0, bus.load}, 0);
        check("rst_ld", {16'd0, bus.ld_h1, bus.ld_h0, bus.ld_m1, bus.ld_m0}, 0);

        // 23:59 -> both fields wrap to 00
        set_cur(4'd2, 4'd3, 4'd5, 4'd9);
        lc = load_cnt;
        press(0); press(1); press(0); press(1); press(0);
        cyc(3);
        check("wrap_load_count", load_cnt - lc, 1);
        check("wrap_ld", {16'd0, last_ld}, 32'h0000);
        check("wrap_run_after", {31'd0, run_after}, 1);

        // 09:05 -> BCD carries through 10 and 20, minutes wrap at 60
        set_cur(4'd0, 4'd9, 4'd0, 4'd5);
        lc = load_cnt;
        press(0); press(1);
        check("carry_09_10", {24'd0, bus.ld_h1, bus.ld_h0}, 32'h10);
        repeat (9) press(1);
        check("carry_19", {24'd0, bus.ld_h1, bus.ld_h0}, 32'h19);
        press(1);
        check("carry_19_20", {24'd0, bus.ld_h1, bus.ld_h0}, 32'h20);
        press(0);
        repeat (55) press(1);
        press(0);
        cyc(3);
        check("carry_load_count", load_cnt - lc, 1);
        check("carry_ld", {16'd0, last_ld}, 32'h2000);

        // Glitch filtering and a long hold
        set_cur(4'd1, 4'd2, 4'd3, 4'd4);
        lc = load_cnt;
        press(0);
        @(negedge clk) bus.btn_inc = 1'b1;
        cyc(2);
        bus.btn_inc = 1'b0;
        cyc(20);
        check("glitch_hours", {24'd0, bus.ld_h1, bus.ld_h0}, 32'h12);
        check("glitch_mode", {30'd0, bus.mode}, 1);
        bus.btn_mode = 1'b1;
        cyc(1000);
        bus.btn_mode = 1'b0;
        cyc(12);
        check("hold_single_step", {30'd0, bus.mode}, 2);
        tick(); tick(); tick();
        check("hold_timeout_mode", {30'd0, bus.mode}, 0);
        check("hold_no_load", load_cnt - lc, 0);

        // Timeout from SET_H
        lc = load_cnt;
        press(0);
        tick(); tick();
        check("tmo_before", {30'd0, bus.mode}, 1);
        tick();
        check("tmo_mode", {30'd0, bus.mode}, 0);
        check("tmo_run_en", {31'd0, bus.run_en}, 1);
        check("tmo_no_load", load_cnt - lc, 0);

        // Simultaneous MODE+INC in SET_H, then Clear mid-edit in SET_M
        set_cur(4'd0, 4'd7, 4'd4, 4'd5);
        lc = load_cnt;
        press(0);
        @(negedge clk);
        bus.btn_mode = 1'b1; bus.btn_inc = 1'b1;
        cyc(DEB + 6);
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        cyc(DEB + 6);
        check("both_mode", {30'd0, bus.mode}, 2);
        check("both_hours", {24'd0, bus.ld_h1, bus.ld_h0}, 32'h07);
        @(negedge clk) rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(3);
        check("clear_mode", {30'd0, bus.mode}, 0);
        check("clear_run_en", {31'd0, bus.run_en}, 1);
        check("clear_no_load", load_cnt - lc, 0);

`ifdef RELOGIO_SET_BLINK_EN
        press(0);
        tick();
        check("blink_first", {31'd0, bus.blank_h}, 1);
        tick();
        check("blink_second", {31'd0, bus.blank_h}, 0);
        tick();
        cyc(5);
`endif

        // Randomized phase: random button hold lengths, ticks and live times
        hold_m = 1; hold_i = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 60 == 0)
                set_cur(4'($urandom_range(0, 3)), 4'($urandom_range(0, 11)),
                        4'($urandom_range(0, 6)), 4'($urandom_range(0, 11)));
            hold_m--;
            if (hold_m == 0) begin
                bus.btn_mode = ($urandom_range(0, 3) == 0) ? ~bus.btn_mode : bus.btn_mode;
                hold_m = $urandom_range(1, 14);
            end
            hold_i--;
            if (hold_i == 0) begin
                bus.btn_inc = ~bus.btn_inc;
                hold_i = $urandom_range(1, 12);
            end
            bus.tick_1hz = ($urandom_range(0, 29) == 0);
            if (c == 2000) rst = 1'b1;
            if (c == 2002) rst = 1'b0;
        end
        bus.tick_1hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
